// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_pkg
// Brief    : Shared state type and default debounce window for stopwatch_ctrl.
// Revision : 1.0
// ============================================================================
package stopwatch_pkg;

  typedef enum logic [0:0] {
    PAUSED = 1'b0,
    RUN    = 1'b1
  } sw_state_t;

  // 20 ms at a 50 MHz board clock
  localparam int DB_CYCLES_50MHZ = 1000000;

endpackage
`default_nettype wire

// File: rtl/stopwatch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_ctrl_if
// Brief    : Front-panel bundle between the buttons/counter and stopwatch_ctrl.
// Revision : 1.0
// ============================================================================
interface stopwatch_ctrl_if;

  logic key_pause_n;
  logic key_clr_n;
  logic over;
  logic pause;
  logic clr;
  logic over_led;

  modport master (
    output key_pause_n, key_clr_n, over,
    input  pause, clr, over_led
  );

  modport slave (
    input  key_pause_n, key_clr_n, over,
    output pause, clr, over_led
  );

endinterface
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module   : key_debounce
// Brief    : Synchronize, debounce and edge-detect one active-low push-button.
// Revision : 1.0
// ============================================================================
module key_debounce
  import stopwatch_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_50MHZ
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int c_cnt_w = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DB_CYCLES - 1);

  logic [1:0]         r_sync;
  logic [1:0]         r_prime;
  logic               r_armed;
  logic               r_level;
  logic               r_press;
  logic [c_cnt_w-1:0] r_cnt;
  logic               w_sample;
  logic               w_differ;

  assign w_sample = r_sync[1];
  assign w_differ = (w_sample != r_level);

  // r_armed blocks the first press until the key is seen released once the
  // synchronizer holds real samples, so a key held across reset stays silent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= 2'b11;
      r_prime <= 2'b00;
      r_armed <= 1'b0;
      r_level <= 1'b1;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync  <= {r_sync[0], key_n};
      r_prime <= {r_prime[0], 1'b1};
      r_press <= 1'b0;
      if (r_prime[1] && w_sample) begin
        r_armed <= 1'b1;
      end
      if (!w_differ) begin
        r_cnt <= '0;
      end else if (r_cnt == c_cnt_last) begin
        r_cnt   <= '0;
        r_level <= w_sample;
        r_press <= r_armed && !w_sample;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign press = r_press;

endmodule
`default_nettype wire

// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_ctrl
// Brief    : Pause/clear button control and overflow handling for the stopwatch.
// Revision : 1.0
// ============================================================================
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DB_CYCLES    = DB_CYCLES_50MHZ,
  parameter bit STOP_ON_OVER = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  stopwatch_ctrl_if.slave  bus
);

  logic       w_pause_press;
  logic       w_clr_press;
  logic       w_stop;
  logic [1:0] r_over_sync;
  logic       r_over_prev;
  logic       r_over_rise;
  sw_state_t  r_state;
  logic       r_pause;
  logic       r_clr;
  logic       r_over_led;

  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_key_pause (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (bus.key_pause_n),
    .press (w_pause_press)
  );

  key_debounce #(.DB_CYCLES(DB_CYCLES)) u_key_clr (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (bus.key_clr_n),
    .press (w_clr_press)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_over_sync <= 2'b00;
      r_over_prev <= 1'b0;
      r_over_rise <= 1'b0;
    end else begin
      r_over_sync <= {r_over_sync[0], bus.over};
      r_over_prev <= r_over_sync[1];
      r_over_rise <= r_over_sync[1] & ~r_over_prev;
    end
  end

  assign w_stop = r_over_rise & STOP_ON_OVER;

  // Event priority: clear, then overflow stop, then pause toggle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= PAUSED;
      r_pause    <= 1'b1;
      r_clr      <= 1'b0;
      r_over_led <= 1'b0;
    end else begin
      r_clr <= 1'b0;
      if (w_clr_press) begin
        r_state <= PAUSED;
        r_pause <= 1'b1;
        r_clr   <= 1'b1;
      end else if (w_stop) begin
        r_state <= PAUSED;
        r_pause <= 1'b1;
      end else if (w_pause_press) begin
        if (r_state == PAUSED) begin
          r_state <= RUN;
          r_pause <= 1'b0;
        end else begin
          r_state <= PAUSED;
          r_pause <= 1'b1;
        end
      end

      if (w_clr_press) begin
        r_over_led <= 1'b0;
      end else if (r_over_rise) begin
        r_over_led <= 1'b1;
      end
    end
  end

  assign bus.pause    = r_pause;
  assign bus.clr      = r_clr;
  assign bus.over_led = r_over_led;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_stopwatch_ctrl
// Brief    : Directed plus random stimulus for stopwatch_ctrl, both STOP_ON_OVER settings.
// Revision : 1.0
// ============================================================================
module tb_stopwatch_ctrl;

  localparam int DB   = 4;
  localparam int HMAX = 4096;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic kp    = 1'b1;
  logic kc    = 1'b1;
  logic ov    = 1'b0;

  int tests = 0;
  int fails = 0;

  stopwatch_ctrl_if bus1 ();
  stopwatch_ctrl_if bus0 ();

  assign bus1.key_pause_n = kp;
  assign bus1.key_clr_n   = kc;
  assign bus1.over        = ov;
  assign bus0.key_pause_n = kp;
  assign bus0.key_clr_n   = kc;
  assign bus0.over        = ov;

  stopwatch_ctrl #(.DB_CYCLES(DB), .STOP_ON_OVER(1'b1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  stopwatch_ctrl #(.DB_CYCLES(DB), .STOP_ON_OVER(1'b0)) u_dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0)
  );

  always #5 clk = ~clk;

  // Reference model: input history indexed by clock edge since reset release.
  bit hp [HMAX];
  bit hc [HMAX];
  bit ho [HMAX];
  int n;
  bit lvl_p, lvl_c;
  int rel_p, rel_c;
  bit ev_p, ev_c, ev_o;
  bit m_pause [2];
  bit m_clr, m_led;

  function automatic bit kraw(input int sel, input int idx);
    if (idx < 1) return 1'b1;
    return (sel == 0) ? hp[idx] : hc[idx];
  endfunction

  function automatic bit oraw(input int idx);
    if (idx < 1) return 1'b0;
    return ho[idx];
  endfunction

  // True when the last DB synchronized samples all equal v.
  function automatic bit held(input int sel, input bit v);
    for (int d = 2; d <= DB + 1; d++) begin
      if (kraw(sel, n - d) != v) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic model_reset();
    n = 0;
    lvl_p = 1'b1; lvl_c = 1'b1;
    rel_p = 0;    rel_c = 0;
    ev_p = 1'b0;  ev_c = 1'b0; ev_o = 1'b0;
    m_pause[0] = 1'b1; m_pause[1] = 1'b1;
    m_clr = 1'b0; m_led = 1'b0;
  endtask

  task automatic model_edge();
    bit np, nc;
    n++;
    hp[n] = kp; hc[n] = kc; ho[n] = ov;
    if (kp && rel_p == 0) rel_p = n;
    if (kc && rel_c == 0) rel_c = n;
    m_clr = ev_c;
    for (int s = 0; s < 2; s++) begin
      if (ev_c) m_pause[s] = 1'b1;
      else if (ev_o && s == 1) m_pause[s] = 1'b1;
      else if (ev_p) m_pause[s] = !m_pause[s];
    end
    if (ev_c) m_led = 1'b0;
    else if (ev_o) m_led = 1'b1;
    np = 1'b0;
    nc = 1'b0;
    if (held(0, !lvl_p)) begin
      lvl_p = !lvl_p;
      np = !lvl_p && rel_p != 0 && rel_p <= n - 3;
    end
    if (held(1, !lvl_c)) begin
      lvl_c = !lvl_c;
      nc = !lvl_c && rel_c != 0 && rel_c <= n - 3;
    end
    ev_p = np;
    ev_c = nc;
    ev_o = oraw(n - 2) && !oraw(n - 3);
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("pause_s1", bus1.pause,    m_pause[1]);
    chk("clr_s1",   bus1.clr,      m_clr);
    chk("led_s1",   bus1.over_led, m_led);
    chk("pause_s0", bus0.pause,    m_pause[0]);
    chk("clr_s0",   bus0.clr,      m_clr);
    chk("led_s0",   bus0.over_led, m_led);
  endtask

  // Called at a negedge: drive, cross one rising edge, check at the next negedge.
  task automatic cyc(input bit p, input bit c, input bit o);
    kp = p; kc = c; ov = o;
    @(posedge clk);
    if (rst_n && n < HMAX - 1) model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rst_pause", bus1.pause, 1'b1);
    chk("rst_clr",   bus1.clr,   1'b0);
    chk("rst_led",   bus1.over_led, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check_all();
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();

    // Idle after reset
    for (int i = 0; i < 20; i++) cyc(1, 1, 0);
    chk("idle_pause", bus1.pause, 1'b1);

    // Clean press: pause falls on the 7th edge
    for (int i = 1; i <= 10; i++) begin
      cyc(0, 1, 0);
      if (i == 6) chk("press_lat6", bus1.pause, 1'b1);
      if (i == 7) chk("press_lat7", bus1.pause, 1'b0);
    end
    for (int i = 0; i < 10; i++) cyc(1, 1, 0);
    chk("one_toggle", bus1.pause, 1'b0);
    for (int i = 0; i < 10; i++) cyc(0, 1, 0);
    for (int i = 0; i < 10; i++) cyc(1, 1, 0);
    chk("second_press", bus1.pause, 1'b1);

    // Bounce shorter than the window, then a valid 5-cycle press
    for (int g = 0; g < 5; g++) begin
      for (int i = 0; i < 3; i++) cyc(0, 1, 0);
      for (int i = 0; i < 3; i++) cyc(1, 1, 0);
    end
    chk("bounce_hold", bus1.pause, 1'b1);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0);
    for (int i = 0; i < 10; i++) cyc(1, 1, 0);
    chk("bounce_toggle", bus1.pause, 1'b0);

    // Clear and pause together while running
    for (int i = 1; i <= 8; i++) begin
      cyc(0, 0, 0);
      if (i == 7) begin
        chk("both_clr", bus1.clr, 1'b1);
        chk("both_pause", bus1.pause, 1'b1);
      end
      if (i == 8) chk("both_clr_end", bus1.clr, 1'b0);
    end
    for (int i = 0; i < 10; i++) cyc(1, 1, 0);
    chk("both_no_toggle", bus1.pause, 1'b1);

    // Back to RUN, then overflow pulse
    for (int i = 0; i < 6; i++) cyc(0, 1, 0);
    for (int i = 0; i < 8; i++) cyc(1, 1, 0);
    for (int i = 1; i <= 4; i++) begin
      cyc(1, 1, 1);
      if (i == 3) chk("over_lat3", bus1.over_led, 1'b0);
      if (i == 4) begin
        chk("over_stop_s1", bus1.pause, 1'b1);
        chk("over_led_s1", bus1.over_led, 1'b1);
        chk("over_run_s0", bus0.pause, 1'b0);
        chk("over_led_s0", bus0.over_led, 1'b1);
      end
    end
    for (int i = 0; i < 6; i++) cyc(1, 1, 0);
    for (int i = 1; i <= 7; i++) begin
      cyc(1, 0, 0);
      if (i == 7) begin
        chk("over_clr_pulse", bus1.clr, 1'b1);
        chk("over_led_clear", bus1.over_led, 1'b0);
      end
    end
    for (int i = 0; i < 10; i++) cyc(1, 1, 0);

    // Reset mid-debounce with the key held through release
    for (int i = 0; i < 3; i++) cyc(0, 1, 0);
    do_reset();
    for (int i = 0; i < 15; i++) cyc(0, 1, 0);
    chk("held_no_event_s1", bus1.pause, 1'b1);
    chk("held_no_event_s0", bus0.pause, 1'b1);
    for (int i = 0; i < 10; i++) cyc(1, 1, 0);
    for (int i = 1; i <= 8; i++) begin
      cyc(0, 1, 0);
      if (i == 7) chk("repress_toggle", bus1.pause, 1'b0);
    end
    for (int i = 0; i < 10; i++) cyc(1, 1, 0);

    // Randomized segments of keys, bounce and overflow pulses
    for (int k = 0; k < 150; k++) begin
      int len;
      bit p, c, o;
      len = $urandom_range(1, 9);
      p   = ($urandom_range(0, 1) == 0);
      c   = ($urandom_range(0, 5) != 0);
      o   = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < len; i++) cyc(p, c, o);
    end
    for (int i = 0; i < 10; i++) cyc(1, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
